// File: rtl/pret_if.sv
// pret_if: signal bundle between the pret_unit bitstream engine and the
// testbench / external stochastic circuit.
//
// Signals:
//   Bxs  [N] x W  binary inputs, value Bxs[i]/2^W; held stable while rst=1
//   Xs   N        generated unipolar bitstreams, bit i encodes Bxs[i]
//   Xcs  NC       constant 0.5 bitstreams (select lines)
//   Z    1        output bit of the external SC circuit
//   Bz   TW       scaled result, Bz/2^TW estimates P(Z=1) once done=1
//   done 1        run complete, sticky until reset
//
// Timing contract: there is no valid/ready handshake. Z is a combinational
// function of Xs/Xcs in the same cycle and is sampled on every rising edge
// while done=0. Bz is meaningful only when done=1.
interface pret_if #(
  parameter int W    = 6,
  parameter int N    = 2,
  parameter int NC   = 1,
  parameter int CORR = 0
) ();
  localparam int TW = (CORR != 0) ? W + NC : W * N + NC;

  logic [W-1:0]  Bxs [N-1:0];
  logic [N-1:0]  Xs;
  logic [NC-1:0] Xcs;
  logic          Z;
  logic [TW-1:0] Bz;
  logic          done;

  modport master (output Bxs, output Z, input Xs, input Xcs, input Bz, input done);
  modport slave  (input Bxs, input Z, output Xs, output Xcs, output Bz, output done);
endinterface

// File: rtl/pret_unit.sv
// pret_unit: stochastic-computing bitstream engine with progressive-precision
// early termination. The binary inputs are captured at reset, turned into
// bitstreams driven into an external combinational SC circuit, and the
// circuit's output Z is counted for exactly 2^L cycles, where L is the
// stream length the inputs' actual precision needs.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; captures bus.Bxs and starts a run
//   bus  pret_if.slave (Bxs, Z in; Xs, Xcs, Bz, done out)
//
// NC must be at least 1.
module pret_unit #(
  parameter int W    = 6,
  parameter int N    = 2,
  parameter int NC   = 1,
  parameter int CORR = 0
) (
  input  logic   clk,
  input  logic   rst,
  pret_if.slave  bus
);
  localparam int TW = (CORR != 0) ? W + NC : W * N + NC;
  localparam int PW = $clog2(W + 1);
  localparam int LW = $clog2(TW + 1) + 1;

  logic [W-1:0]  bx_q [N-1:0];
  logic [TW-1:0] c_q, c_d;
  logic [TW:0]   cnt_q, cnt_d;
  logic [TW-1:0] bz_q, bz_d;
  logic          done_q, done_d;

  logic [PW-1:0] prec [N-1:0];
  logic [PW-1:0] pmax;
  logic [LW-1:0] len_l;
  logic [TW:0]   last_c;
  logic          at_last;
  logic [N-1:0]  xs;

  // Precision of each input: W minus its trailing zeros, 0 for a zero input.
  // The scan runs MSB to LSB so the lowest set bit wins.
  always_comb begin
    pmax = '0;
    for (int i = 0; i < N; i++) begin
      prec[i] = '0;
      for (int k = W - 1; k >= 0; k--) begin
        if (bx_q[i][k]) prec[i] = PW'(W - k);
      end
      if (prec[i] > pmax) pmax = prec[i];
    end
  end

  // Stream length exponent and the terminal counter value 2^L - 1.
  always_comb begin
    len_l = LW'(NC);
    if (CORR != 0) begin
      len_l = len_l + LW'(pmax);
    end else begin
      for (int i = 0; i < N; i++) len_l = len_l + LW'(prec[i]);
    end
    last_c  = ((TW + 1)'(1) << len_l) - (TW + 1)'(1);
    at_last = ({1'b0, c_q} == last_c);
  end

  // Stream generation. The counter is mixed-radix, LSB first: NC select
  // bits, then one Pi-bit field per input (or one shared Pmax field when
  // correlated). Bit-reversing a Pi-bit field walks the multiples of
  // 2^(W-Pi), so each stream is exact over its period.
  logic [TW-1:0] fld_raw;
  logic [W:0]    one_sh;
  logic [W-1:0]  fld;
  logic [W-1:0]  rev;
  logic [LW-1:0] off;

  always_comb begin
    xs      = '0;
    off     = LW'(NC);
    fld_raw = '0;
    one_sh  = '0;
    fld     = '0;
    rev     = '0;
    for (int i = 0; i < N; i++) begin
      if (CORR != 0) begin
        fld_raw = c_q >> NC;
        one_sh  = (W + 1)'(1) << pmax;
      end else begin
        fld_raw = c_q >> off;
        one_sh  = (W + 1)'(1) << prec[i];
        off     = off + LW'(prec[i]);
      end
      fld = fld_raw[W-1:0] & W'(one_sh - (W + 1)'(1));
      for (int k = 0; k < W; k++) rev[W-1-k] = fld[k];
      xs[i] = !done_q && (rev < bx_q[i]);
    end
  end

  // Counting and termination.
  logic [TW:0] cnt_sum;
  logic [TW:0] shifted;

  always_comb begin
    c_d     = c_q;
    cnt_d   = cnt_q;
    bz_d    = bz_q;
    done_d  = done_q;
    cnt_sum = cnt_q + {{TW{1'b0}}, bus.Z};
    shifted = cnt_sum << (LW'(TW) - len_l);
    if (!done_q) begin
      cnt_d = cnt_sum;
      if (at_last) begin
        done_d = 1'b1;
        // Only a full-length run with Z stuck at 1 reaches 2^TW.
        bz_d   = shifted[TW] ? '1 : shifted[TW-1:0];
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bx_q[i] <= bus.Bxs[i];
      c_q    <= '0;
      cnt_q  <= '0;
      bz_q   <= '0;
      done_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      bz_q   <= bz_d;
      done_q <= done_d;
    end
  end

  assign bus.Xs   = xs;
  assign bus.Xcs  = done_q ? '0 : c_q[NC-1:0];
  assign bus.Bz   = bz_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_pret_unit.sv
// tb_pret_unit: self-checking bench for pret_unit. Two instances are built,
// one independent-source (CORR=0, TW=13) and one correlated (CORR=1, TW=7).
// The bench supplies the external SC circuit as a selectable function of
// Xs/Xcs and predicts every cycle's streams and the final result from the
// arithmetic definition of the mixed-radix sequence.
module tb_pret_unit;
  localparam int W  = 6;
  localparam int N  = 2;
  localparam int NC = 1;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   z_mode = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  // Expected {Xcs, Xs[1], Xs[0]} for each cycle of the current run.
  logic [N+NC-1:0] exp_q[$];

  always #5 clk = ~clk;

  pret_if #(.W(W), .N(N), .NC(NC), .CORR(0)) b0 ();
  pret_if #(.W(W), .N(N), .NC(NC), .CORR(1)) b1 ();

  pret_unit #(.W(W), .N(N), .NC(NC), .CORR(0)) u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  pret_unit #(.W(W), .N(N), .NC(NC), .CORR(1)) u1 (.clk(clk), .rst(rst1), .bus(b1.slave));

  // External SC circuit variants.
  function automatic logic z_fn(input int mode, input logic [1:0] x, input logic xc);
    case (mode)
      0:       return xc ? x[0] : x[1];
      1:       return x[0] & x[1];
      2:       return xc;
      3:       return 1'b1;
      4:       return x[0] ^ x[1] ^ xc;
      default: return 1'b0;
    endcase
  endfunction

  always_comb b0.Z = z_fn(z_mode, b0.Xs, b0.Xcs[0]);
  always_comb b1.Z = z_fn(z_mode, b1.Xs, b1.Xcs[0]);

  function automatic logic [2:0] get_streams(input int sel);
    return (sel != 0) ? {b1.Xcs, b1.Xs} : {b0.Xcs, b0.Xs};
  endfunction

  function automatic logic get_done(input int sel);
    return (sel != 0) ? b1.done : b0.done;
  endfunction

  function automatic logic [12:0] get_bz(input int sel);
    return (sel != 0) ? {6'd0, b1.Bz} : b0.Bz;
  endfunction

  // ---------------- reference model ----------------
  function automatic int prec_of(input int v);
    int p;
    p = W;
    if (v == 0) return 0;
    while (v % 2 == 0) begin
      v = v / 2;
      p--;
    end
    return p;
  endfunction

  function automatic int bitrev_w(input int f);
    int r;
    r = 0;
    for (int k = 0; k < W; k++) r = r * 2 + ((f >> k) & 1);
    return r;
  endfunction

  // Fills exp_q with the run's streams and returns the expected Bz.
  task automatic build_model(input int sel, input int v0, input int v1, input int mode,
                             output longint bz_exp);
    int p0, p1, len, tw, xcs, rem, f0, f1, ones;
    logic x0, x1;
    longint e;
    p0 = prec_of(v0);
    p1 = prec_of(v1);
    tw = (sel != 0) ? W + NC : W * N + NC;
    if (sel != 0) len = NC + ((p0 > p1) ? p0 : p1);
    else          len = NC + p0 + p1;
    exp_q.delete();
    ones = 0;
    for (int t = 0; t < (1 << len); t++) begin
      xcs = t % (1 << NC);
      rem = t / (1 << NC);
      if (sel != 0) begin
        f0 = rem;
        f1 = rem;
      end else begin
        f0  = rem % (1 << p0);
        rem = rem / (1 << p0);
        f1  = rem % (1 << p1);
      end
      x0 = (bitrev_w(f0) < v0);
      x1 = (bitrev_w(f1) < v1);
      exp_q.push_back({xcs[0], x1, x0});
      ones += int'(z_fn(mode, {x1, x0}, xcs[0]));
    end
    e = longint'(ones) << (tw - len);
    if (e >= (longint'(1) << tw)) e = (longint'(1) << tw) - 1;
    bz_exp = e;
  endtask

  // Resets the selected unit with new inputs and follows the run cycle by
  // cycle. stop_after >= 0 abandons the run after that many cycles.
  task automatic do_run(input int sel, input int v0, input int v1, input int mode,
                        input int stop_after, output logic [12:0] bz_got,
                        output int hi0, output int hi1);
    longint bz_exp;
    int runlen;
    logic [2:0] got, exp;
    hi0 = 0;
    hi1 = 0;
    bz_got = '0;
    z_mode = mode;
    build_model(sel, v0, v1, mode, bz_exp);
    runlen = exp_q.size();
    @(negedge clk);
    if (sel != 0) begin
      b1.Bxs[0] = 6'(v0); b1.Bxs[1] = 6'(v1); rst1 = 1'b1;
    end else begin
      b0.Bxs[0] = 6'(v0); b0.Bxs[1] = 6'(v1); rst0 = 1'b1;
    end
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int t = 0; t < runlen; t++) begin
      if (stop_after >= 0 && t == stop_after) return;
      exp = exp_q.pop_front();
      got = get_streams(sel);
      hi0 += int'(got[0]);
      hi1 += int'(got[1]);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL streams sel=%0d t=%0d got=%b exp=%b", sel, t, got, exp);
      end
      n_cmp++;
      if (get_done(sel) !== 1'b0) begin
        n_bad++;
        $display("FAIL early_done sel=%0d t=%0d got=%b exp=0", sel, t, get_done(sel));
      end
      n_cmp++;
      if (get_bz(sel) !== 13'd0) begin
        n_bad++;
        $display("FAIL bz_running sel=%0d t=%0d got=%0d exp=0", sel, t, get_bz(sel));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (get_done(sel) !== 1'b1) begin
      n_bad++;
      $display("FAIL done_at_end sel=%0d len=%0d got=%b exp=1", sel, runlen, get_done(sel));
    end
    bz_got = get_bz(sel);
    n_cmp++;
    if (bz_got !== 13'(bz_exp)) begin
      n_bad++;
      $display("FAIL bz_final sel=%0d got=%0d exp=%0d", sel, bz_got, bz_exp);
    end
    n_cmp++;
    if (get_streams(sel) !== 3'b000) begin
      n_bad++;
      $display("FAIL streams_after_done sel=%0d got=%b exp=000", sel, get_streams(sel));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    b0.Bxs[0] = 6'b010000; b0.Bxs[1] = 6'b110000;
    b1.Bxs[0] = 6'b010000; b1.Bxs[1] = 6'b110000;
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (b0.done !== 1'b0 || b1.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done got=%b%b exp=00", b0.done, b1.done);
    end
    n_cmp++;
    if (b0.Bz !== 13'd0 || b1.Bz !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_bz got=%0d,%0d exp=0,0", b0.Bz, b1.Bz);
    end
    // c=0: select low, every non-zero input stream high.
    n_cmp++;
    if ({b0.Xcs, b0.Xs} !== 3'b011 || {b1.Xcs, b1.Xs} !== 3'b011) begin
      n_bad++;
      $display("FAIL reset_streams got=%b,%b exp=011,011", {b0.Xcs, b0.Xs}, {b1.Xcs, b1.Xs});
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic test_directed();
    logic [12:0] bz;
    int h0, h1;
    do_run(0, 6'b010000, 6'b110000, 0, -1, bz, h0, h1);
    n_cmp++;
    if (bz !== 13'd4096) begin
      n_bad++;
      $display("FAIL dir_mux got=%0d exp=4096", bz);
    end
    do_run(0, 6'b000001, 6'b000000, 0, -1, bz, h0, h1);
    n_cmp++;
    if (bz !== 13'd64 || h0 != 2 || h1 != 0) begin
      n_bad++;
      $display("FAIL dir_fine got bz=%0d hi0=%0d hi1=%0d exp 64 2 0", bz, h0, h1);
    end
    do_run(1, 6'b010000, 6'b110000, 1, -1, bz, h0, h1);
    n_cmp++;
    if (bz !== 13'd32 || h0 != 2 || h1 != 6) begin
      n_bad++;
      $display("FAIL dir_corr got bz=%0d hi0=%0d hi1=%0d exp 32 2 6", bz, h0, h1);
    end
    do_run(0, 0, 0, 2, -1, bz, h0, h1);
    n_cmp++;
    if (bz !== 13'd4096) begin
      n_bad++;
      $display("FAIL dir_zero got=%0d exp=4096", bz);
    end
  endtask

  task automatic test_saturate();
    logic [12:0] bz;
    int h0, h1;
    // L = TW on the correlated unit with Z stuck at 1: count 128 clamps to 127.
    do_run(1, 6'b000011, 6'b100000, 3, -1, bz, h0, h1);
    n_cmp++;
    if (bz !== 13'd127) begin
      n_bad++;
      $display("FAIL saturate got=%0d exp=127", bz);
    end
  endtask

  task automatic test_random();
    logic [12:0] bz;
    int h0, h1, v0, v1;
    for (int r = 0; r < 6; r++) begin
      v0 = int'($urandom_range(0, 63)) & ((63 << $urandom_range(0, 5)) & 63);
      v1 = int'($urandom_range(0, 63)) & ((63 << $urandom_range(1, 6)) & 63);
      do_run(r % 2, v0, v1, int'($urandom_range(0, 4)), -1, bz, h0, h1);
    end
  endtask

  task automatic test_midrun_reset();
    logic [12:0] bz;
    int h0, h1;
    do_run(0, 6'b111111, 6'b101011, 4, 5, bz, h0, h1);
    // do_run reasserts reset mid-run and checks the fresh run from c=0.
    do_run(0, 6'b001000, 6'b000100, 4, -1, bz, h0, h1);
    do_run(1, 6'b111111, 6'b000001, 0, 9, bz, h0, h1);
    do_run(1, 6'b100000, 6'b000000, 0, -1, bz, h0, h1);
  endtask

  task automatic test_hold_after_done();
    logic [12:0] bz;
    int h0, h1;
    do_run(0, 6'b011000, 6'b100000, 0, -1, bz, h0, h1);
    z_mode = 3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (b0.Bz !== bz || b0.done !== 1'b1 || {b0.Xcs, b0.Xs} !== 3'b000) begin
        n_bad++;
        $display("FAIL hold k=%0d got bz=%0d done=%b str=%b exp bz=%0d done=1 str=000",
                 k, b0.Bz, b0.done, {b0.Xcs, b0.Xs}, bz);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < N; i++) begin
      b0.Bxs[i] = '0;
      b1.Bxs[i] = '0;
    end
    test_reset();
    test_directed();
    test_saturate();
    test_random();
    test_midrun_reset();
    test_hold_after_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
